pulse_trigger_ctrl: RTL and testbench
=====================================

Name: pulse_trigger_ctrl

Overview:
Sequencer between the pulse register (queued pulse parameters) and the pulse generator (NCO/envelope datapath).
- Takes one queued pulse at a time through a valid/ready handshake.
- Holds it until the global timebase counter reaches its t_start.
- Drives the generator for exactly t_len cycles, with a per-cycle envelope address.
- Detects and reports late pulses, and supports abort.

Parameters:
TIME_W, 32, width of global counter and t_start
FREQ_W, 32, frequency word width
PHASE_W, 16, phase word width
AMP_W, 16, amplitude width
TLEN_W, 16, pulse length width (cycles)
ENV_ADDR_W, 10, envelope memory address width
DROP_LATE, 0, 0 = play late pulse immediately; 1 = discard late pulse

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
counter  in  TIME_W  global timebase (free-running, wraps)
enable  in  1  permit accepting new pulses
abort  in  1  synchronous kill of held/playing pulse
in_valid  in  1  pulse register has a pulse
in_ready  out  1  controller accepts pulse this cycle
in_freq/in_phase/in_amp  in  FREQ_W/PHASE_W/AMP_W  pulse parameters
in_tstart  in  TIME_W  start time
in_tlen  in  TLEN_W  length in cycles
in_env_addr  in  ENV_ADDR_W  envelope base address
gen_valid  out  1  generator sample strobe
gen_first  out  1  first beat of pulse
gen_last  out  1  last beat of pulse
gen_freq/gen_phase/gen_amp  out  FREQ_W/PHASE_W/AMP_W  held parameters
gen_env_addr  out  ENV_ADDR_W  envelope address for this beat
busy  out  1  state != IDLE
late_err  out  1  one-cycle late-pulse flag
late_count  out  8  saturating late-pulse count
pulses_done  out  16  saturating completed-pulse count

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including gen_* fields and both counters.
- States: IDLE, ARMED, PLAY. All gen_* outputs are registered.
- Handshake: transfer occurs when in_valid & in_ready. in_ready is combinational:
  - high when enable & !abort & (state==IDLE, or state==PLAY and current beat is last).
  - This allows back-to-back pulses.
- On transfer: latch all in_* fields, then go to ARMED.
  - If in_tlen==0: go to IDLE instead (pulse consumed, no output, no count).
- Time compare: diff = t_start - counter, modulo 2^TIME_W, interpreted as signed.
  - diff==0: due.
  - diff MSB set: late.
  - Window is ±2^(TIME_W-1).
- ARMED, first cycle:
  - If late: assert late_err for one cycle and increment late_count.
  - If late and DROP_LATE=1: go to IDLE.
  - If late and DROP_LATE=0: go to PLAY.
- ARMED, otherwise: wait; go to PLAY in the cycle counter==t_start.
- Latency: first gen_valid occurs in the cycle counter==t_start+1. This is fixed and documented; upstream compensates.
- PLAY:
  - gen_valid high for exactly t_len consecutive cycles.
  - beat index i runs 0..t_len-1.
  - gen_env_addr = env_addr + i, modulo 2^ENV_ADDR_W (wraps silently).
  - gen_first is high at i=0; gen_last is high at i=t_len-1. Both are high together when t_len=1.
  - gen_freq/phase/amp are held constant.
- After the last beat:
  - pulses_done increments.
  - Go to ARMED if a new transfer occurred in that cycle, else IDLE.
- abort has highest priority:
  - Next state is IDLE and the held pulse is discarded.
  - gen_valid is 0 from the next cycle.
  - No pulses_done increment; in_ready is 0 in the abort cycle.
  - abort while IDLE has no effect.
- enable low: no new accepts; the in-flight pulse (ARMED or PLAY) completes normally.
- Counter wrap: compare is modular, so a t_start just past a wrap is handled correctly.
- Both counters saturate at their maximum: 255 and 65535.
- Outside PLAY: gen_valid/first/last are 0; gen_* data fields hold their last value.

Decomposition:
- Shared package pulse_pkg:
  - width constants (TIME_W, FREQ_W, PHASE_W, AMP_W, TLEN_W, ENV_ADDR_W);
  - pulse_t struct (freq, phase, amp, tstart, tlen, env_addr);
  - state enum for this block.
- Sub-module pulse_time_cmp: combinational wrap-aware compare of t_start vs counter, producing due and late outputs. Reusable by other schedulers.

Test Plan:
1. counter=100, pulse tstart=110, tlen=4, env_addr=0x3FE → gen_valid at counter 111..114; env_addr sequence 0x3FE,0x3FF,0x000,0x001; gen_first at 111, gen_last at 114; pulses_done=1.
2. Two pulses queued (tstart=50 tlen=3, tstart=53 tlen=2), in_valid continuous → second accepted on first pulse's last beat; gen_valid contiguous at counter 51..55.
3. counter=200, pulse tstart=150:
   - DROP_LATE=0 → late_err 1 cycle, late_count=1, pulse plays immediately.
   - DROP_LATE=1 → no gen_valid, state IDLE, late_count=1.
4. counter near wrap 0xFFFFFFFE, tstart=0x00000002 tlen=1 → treated as future; single beat at counter 0x00000003.
5. abort on second beat of tlen=8 pulse → gen_valid low next cycle, pulses_done unchanged, busy=0; in_tlen=0 pulse → consumed, no gen_valid.
6. rst_n asserted mid-PLAY → all outputs 0 immediately; after release, enable=0 blocks in_ready with in_valid=1.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared widths, pulse descriptor and sequencer state encoding for the
// pulse register / trigger controller / generator slice.
package pulse_pkg;

  localparam int TIME_W     = 32;
  localparam int FREQ_W     = 32;
  localparam int PHASE_W    = 16;
  localparam int AMP_W      = 16;
  localparam int TLEN_W     = 16;
  localparam int ENV_ADDR_W = 10;

  typedef struct packed {
    logic [FREQ_W-1:0]     freq;
    logic [PHASE_W-1:0]    phase;
    logic [AMP_W-1:0]      amp;
    logic [TIME_W-1:0]     tstart;
    logic [TLEN_W-1:0]     tlen;
    logic [ENV_ADDR_W-1:0] env_addr;
  } pulse_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } ptc_state_e;

endpackage

// File: rtl/pulse_time_cmp.sv
// Wrap-aware compare of a scheduled start time against the free-running
// timebase. The modular difference is read as signed, so the usable window
// is +/- 2^(W-1) cycles around the current count.
module pulse_time_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] tstart_i,
  input  logic [W-1:0] counter_i,
  output logic         due_o,
  output logic         late_o
);

  logic [W-1:0] diff;

  assign diff   = tstart_i - counter_i;
  assign due_o  = (diff == '0);
  assign late_o = diff[W-1];

endmodule

// File: rtl/pulse_trigger_ctrl.sv
// Sequencer between the pulse register and the pulse generator: accepts one
// pulse, holds it until its start time, then plays it for t_len beats.
// The arm/late decision for a newly accepted pulse is taken in the transfer
// cycle itself, so a pulse accepted on the previous pulse's last beat and
// due in that same cycle plays without a gap.
module pulse_trigger_ctrl
  import pulse_pkg::*;
#(
  parameter bit DROP_LATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_W-1:0]     counter,
  input  logic                  enable,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FREQ_W-1:0]     in_freq,
  input  logic [PHASE_W-1:0]    in_phase,
  input  logic [AMP_W-1:0]      in_amp,
  input  logic [TIME_W-1:0]     in_tstart,
  input  logic [TLEN_W-1:0]     in_tlen,
  input  logic [ENV_ADDR_W-1:0] in_env_addr,
  output logic                  gen_valid,
  output logic                  gen_first,
  output logic                  gen_last,
  output logic [FREQ_W-1:0]     gen_freq,
  output logic [PHASE_W-1:0]    gen_phase,
  output logic [AMP_W-1:0]      gen_amp,
  output logic [ENV_ADDR_W-1:0] gen_env_addr,
  output logic                  busy,
  output logic                  late_err,
  output logic [7:0]            late_count,
  output logic [15:0]           pulses_done
);

  ptc_state_e            state_q, state_d;
  pulse_t                pulse_q, in_pulse, src_pulse;
  logic [TLEN_W-1:0]     beat_q;
  logic                  gen_valid_q, gen_first_q, gen_last_q;
  logic [FREQ_W-1:0]     gen_freq_q;
  logic [PHASE_W-1:0]    gen_phase_q;
  logic [AMP_W-1:0]      gen_amp_q;
  logic [ENV_ADDR_W-1:0] gen_env_addr_q;
  logic                  late_err_q;
  logic [7:0]            late_count_q;
  logic [15:0]           pulses_done_q;

  logic transfer, take_new, due, late, start_play, late_hit, last_beat;

  // Pack the incoming pulse fields into one descriptor
  always_comb begin
    in_pulse          = '0;
    in_pulse.freq     = in_freq;
    in_pulse.phase    = in_phase;
    in_pulse.amp      = in_amp;
    in_pulse.tstart   = in_tstart;
    in_pulse.tlen     = in_tlen;
    in_pulse.env_addr = in_env_addr;
  end

  // While armed the held pulse is timed; otherwise the one being offered
  assign src_pulse = (state_q == ST_ARMED) ? pulse_q : in_pulse;

  pulse_time_cmp #(.W(TIME_W)) u_cmp (
    .tstart_i  (src_pulse.tstart),
    .counter_i (counter),
    .due_o     (due),
    .late_o    (late)
  );

  assign last_beat  = (state_q == ST_PLAY) && gen_last_q;
  assign in_ready   = enable && !abort && ((state_q == ST_IDLE) || last_beat);
  assign transfer   = in_valid && in_ready;
  assign take_new   = transfer && (in_tlen != '0);
  assign late_hit   = take_new && late;
  assign start_play = !abort &&
                      (((state_q == ST_ARMED) && (due || late)) ||
                       (take_new && (due || (late && !DROP_LATE))));

  // Next-state selection; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: if (start_play) state_d = ST_PLAY;
      ST_PLAY:  if (gen_last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (transfer) begin
      if (start_play)             state_d = ST_PLAY;
      else if (take_new && !late) state_d = ST_ARMED;
      else                        state_d = ST_IDLE;
    end
    if (abort) state_d = ST_IDLE;
  end

  // Sequencer state, held pulse, registered generator drive and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pulse_q        <= '0;
      beat_q         <= '0;
      gen_valid_q    <= 1'b0;
      gen_first_q    <= 1'b0;
      gen_last_q     <= 1'b0;
      gen_freq_q     <= '0;
      gen_phase_q    <= '0;
      gen_amp_q      <= '0;
      gen_env_addr_q <= '0;
      late_err_q     <= 1'b0;
      late_count_q   <= '0;
      pulses_done_q  <= '0;
    end else begin
      state_q    <= state_d;
      late_err_q <= late_hit;
      if (transfer) pulse_q <= in_pulse;
      if (late_hit && (late_count_q != 8'hFF))
        late_count_q <= late_count_q + 8'd1;
      if (last_beat && !abort && (pulses_done_q != 16'hFFFF))
        pulses_done_q <= pulses_done_q + 16'd1;

      if (start_play) begin
        gen_valid_q    <= 1'b1;
        gen_first_q    <= 1'b1;
        gen_last_q     <= (src_pulse.tlen == TLEN_W'(1));
        gen_freq_q     <= src_pulse.freq;
        gen_phase_q    <= src_pulse.phase;
        gen_amp_q      <= src_pulse.amp;
        gen_env_addr_q <= src_pulse.env_addr;
        beat_q         <= '0;
      end else if ((state_q == ST_PLAY) && !gen_last_q && !abort) begin
        gen_first_q    <= 1'b0;
        gen_last_q     <= ((beat_q + TLEN_W'(1)) == (pulse_q.tlen - TLEN_W'(1)));
        gen_env_addr_q <= gen_env_addr_q + ENV_ADDR_W'(1);
        beat_q         <= beat_q + TLEN_W'(1);
      end else begin
        gen_valid_q <= 1'b0;
        gen_first_q <= 1'b0;
        gen_last_q  <= 1'b0;
      end
    end
  end

  assign gen_valid    = gen_valid_q;
  assign gen_first    = gen_first_q;
  assign gen_last     = gen_last_q;
  assign gen_freq     = gen_freq_q;
  assign gen_phase    = gen_phase_q;
  assign gen_amp      = gen_amp_q;
  assign gen_env_addr = gen_env_addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign late_err     = late_err_q;
  assign late_count   = late_count_q;
  assign pulses_done  = pulses_done_q;

endmodule

// File: tb/tb_pulse_trigger_ctrl.sv
// Directed bench for pulse_trigger_ctrl. Two instances share all inputs:
// d0 plays late pulses, d1 discards them.
module tb_pulse_trigger_ctrl;

  logic        clk, rst_n, enable, abort, in_valid;
  logic [31:0] counter, in_freq, in_tstart;
  logic [15:0] in_phase, in_amp, in_tlen;
  logic [9:0]  in_env_addr;

  logic        d0_in_ready, d0_gen_valid, d0_gen_first, d0_gen_last, d0_busy, d0_late_err;
  logic [31:0] d0_gen_freq;
  logic [15:0] d0_gen_phase, d0_gen_amp, d0_pulses_done;
  logic [9:0]  d0_gen_env_addr;
  logic [7:0]  d0_late_count;

  logic        d1_in_ready, d1_gen_valid, d1_gen_first, d1_gen_last, d1_busy, d1_late_err;
  logic [31:0] d1_gen_freq;
  logic [15:0] d1_gen_phase, d1_gen_amp, d1_pulses_done;
  logic [9:0]  d1_gen_env_addr;
  logic [7:0]  d1_late_count;

  int checks = 0;
  int errors = 0;

  pulse_trigger_ctrl #(.DROP_LATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .counter(counter), .enable(enable), .abort(abort),
    .in_valid(in_valid), .in_ready(d0_in_ready), .in_freq(in_freq), .in_phase(in_phase),
    .in_amp(in_amp), .in_tstart(in_tstart), .in_tlen(in_tlen), .in_env_addr(in_env_addr),
    .gen_valid(d0_gen_valid), .gen_first(d0_gen_first), .gen_last(d0_gen_last),
    .gen_freq(d0_gen_freq), .gen_phase(d0_gen_phase), .gen_amp(d0_gen_amp),
    .gen_env_addr(d0_gen_env_addr), .busy(d0_busy), .late_err(d0_late_err),
    .late_count(d0_late_count), .pulses_done(d0_pulses_done)
  );

  pulse_trigger_ctrl #(.DROP_LATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .counter(counter), .enable(enable), .abort(abort),
    .in_valid(in_valid), .in_ready(d1_in_ready), .in_freq(in_freq), .in_phase(in_phase),
    .in_amp(in_amp), .in_tstart(in_tstart), .in_tlen(in_tlen), .in_env_addr(in_env_addr),
    .gen_valid(d1_gen_valid), .gen_first(d1_gen_first), .gen_last(d1_gen_last),
    .gen_freq(d1_gen_freq), .gen_phase(d1_gen_phase), .gen_amp(d1_gen_amp),
    .gen_env_addr(d1_gen_env_addr), .busy(d1_busy), .late_err(d1_late_err),
    .late_count(d1_late_count), .pulses_done(d1_pulses_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: the timebase advances just after the edge the DUT sampled
  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 32'd1;
  endtask

  task automatic setp(input logic [31:0] ts, input logic [15:0] tl, input logic [9:0] ea);
    in_tstart   = ts;
    in_tlen     = tl;
    in_env_addr = ea;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; abort = 1'b0; in_valid = 1'b0; counter = 32'd0;
    in_freq = 32'h1234_5678; in_phase = 16'h1111; in_amp = 16'h2222;
    in_tstart = 32'd0; in_tlen = 16'd0; in_env_addr = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(d0_gen_valid), 32'd0);
    chk("rst_busy", 32'(d0_busy), 32'd0);
    chk("rst_freq", d0_gen_freq, 32'd0);
    chk("rst_late_cnt", 32'(d0_late_count), 32'd0);
    chk("rst_done", 32'(d0_pulses_done), 32'd0);
    rst_n = 1'b1;

    // 1: future pulse, env address wraps across 0x3FF
    enable = 1'b1; counter = 32'd100; setp(32'd110, 16'd4, 10'h3FE); in_valid = 1'b1;
    #1;
    chk("t1_ready", 32'(d0_in_ready), 32'd1);
    chk("t1_ready_d1", 32'(d1_in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    repeat (9) tick();
    chk("t1_pre_valid", 32'(d0_gen_valid), 32'd0);
    chk("t1_pre_busy", 32'(d0_busy), 32'd1);
    tick();
    chk("t1_cnt", counter, 32'd111);
    chk("t1_b0_valid", 32'(d0_gen_valid), 32'd1);
    chk("t1_b0_first", 32'(d0_gen_first), 32'd1);
    chk("t1_b0_last", 32'(d0_gen_last), 32'd0);
    chk("t1_b0_env", 32'(d0_gen_env_addr), 32'h3FE);
    chk("t1_freq", d0_gen_freq, 32'h1234_5678);
    chk("t1_phase", 32'(d0_gen_phase), 32'h1111);
    chk("t1_amp", 32'(d0_gen_amp), 32'h2222);
    chk("t1_d1_valid", 32'(d1_gen_valid), 32'd1);
    chk("t1_d1_first", 32'(d1_gen_first), 32'd1);
    chk("t1_d1_last", 32'(d1_gen_last), 32'd0);
    chk("t1_d1_freq", d1_gen_freq, 32'h1234_5678);
    chk("t1_d1_phase", 32'(d1_gen_phase), 32'h1111);
    chk("t1_d1_amp", 32'(d1_gen_amp), 32'h2222);
    chk("t1_d1_env", 32'(d1_gen_env_addr), 32'h3FE);
    tick();
    chk("t1_b1_env", 32'(d0_gen_env_addr), 32'h3FF);
    chk("t1_b1_first", 32'(d0_gen_first), 32'd0);
    tick();
    chk("t1_b2_env", 32'(d0_gen_env_addr), 32'h000);
    chk("t1_b2_valid", 32'(d0_gen_valid), 32'd1);
    tick();
    chk("t1_b3_env", 32'(d0_gen_env_addr), 32'h001);
    chk("t1_b3_last", 32'(d0_gen_last), 32'd1);
    chk("t1_b3_done", 32'(d0_pulses_done), 32'd0);
    tick();
    chk("t1_end_valid", 32'(d0_gen_valid), 32'd0);
    chk("t1_end_busy", 32'(d0_busy), 32'd0);
    chk("t1_end_done", 32'(d0_pulses_done), 32'd1);

    // 2: back-to-back pulses, second accepted on first's last beat
    counter = 32'd45; setp(32'd50, 16'd3, 10'h010); in_valid = 1'b1;
    #1;
    tick();
    setp(32'd53, 16'd2, 10'h020);
    #1;
    chk("t2_armed_ready", 32'(d0_in_ready), 32'd0);
    repeat (5) tick();
    chk("t2_51_valid", 32'(d0_gen_valid), 32'd1);
    chk("t2_51_env", 32'(d0_gen_env_addr), 32'h010);
    tick();
    chk("t2_52_ready", 32'(d0_in_ready), 32'd0);
    tick();
    chk("t2_53_last", 32'(d0_gen_last), 32'd1);
    chk("t2_53_ready", 32'(d0_in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("t2_54_valid", 32'(d0_gen_valid), 32'd1);
    chk("t2_54_first", 32'(d0_gen_first), 32'd1);
    chk("t2_54_env", 32'(d0_gen_env_addr), 32'h020);
    chk("t2_54_done", 32'(d0_pulses_done), 32'd2);
    tick();
    chk("t2_55_valid", 32'(d0_gen_valid), 32'd1);
    chk("t2_55_last", 32'(d0_gen_last), 32'd1);
    chk("t2_55_env", 32'(d0_gen_env_addr), 32'h021);
    tick();
    chk("t2_56_valid", 32'(d0_gen_valid), 32'd0);
    chk("t2_56_done", 32'(d0_pulses_done), 32'd3);

    // 3: late pulse, played by d0 and dropped by d1
    counter = 32'd200; setp(32'd150, 16'd2, 10'h040); in_valid = 1'b1;
    #1;
    tick(); in_valid = 1'b0;
    chk("t3_d0_late", 32'(d0_late_err), 32'd1);
    chk("t3_d0_lcnt", 32'(d0_late_count), 32'd1);
    chk("t3_d0_valid", 32'(d0_gen_valid), 32'd1);
    chk("t3_d0_env", 32'(d0_gen_env_addr), 32'h040);
    chk("t3_d1_late", 32'(d1_late_err), 32'd1);
    chk("t3_d1_lcnt", 32'(d1_late_count), 32'd1);
    chk("t3_d1_valid", 32'(d1_gen_valid), 32'd0);
    chk("t3_d1_busy", 32'(d1_busy), 32'd0);
    tick();
    chk("t3_d0_late_clr", 32'(d0_late_err), 32'd0);
    chk("t3_d0_last", 32'(d0_gen_last), 32'd1);
    tick();
    chk("t3_d0_end_valid", 32'(d0_gen_valid), 32'd0);
    chk("t3_d0_done", 32'(d0_pulses_done), 32'd4);
    chk("t3_d1_done", 32'(d1_pulses_done), 32'd3);

    // 4: start time just past counter wrap is in the future
    counter = 32'hFFFF_FFFE; setp(32'h0000_0002, 16'd1, 10'h055); in_valid = 1'b1;
    #1;
    tick(); in_valid = 1'b0;
    chk("t4_late", 32'(d0_late_err), 32'd0);
    chk("t4_busy", 32'(d0_busy), 32'd1);
    repeat (3) tick();
    chk("t4_2_valid", 32'(d0_gen_valid), 32'd0);
    tick();
    chk("t4_3_cnt", counter, 32'd3);
    chk("t4_3_valid", 32'(d0_gen_valid), 32'd1);
    chk("t4_3_first", 32'(d0_gen_first), 32'd1);
    chk("t4_3_last", 32'(d0_gen_last), 32'd1);
    chk("t4_3_env", 32'(d0_gen_env_addr), 32'h055);
    tick();
    chk("t4_4_valid", 32'(d0_gen_valid), 32'd0);
    chk("t4_done", 32'(d0_pulses_done), 32'd5);
    chk("t4_lcnt", 32'(d0_late_count), 32'd1);

    // 5: abort on second beat, abort while idle, zero-length pulse
    counter = 32'd300; setp(32'd305, 16'd8, 10'h000); in_valid = 1'b1;
    #1;
    tick(); in_valid = 1'b0;
    repeat (5) tick();
    chk("t5_b0_valid", 32'(d0_gen_valid), 32'd1);
    tick();
    chk("t5_b1_env", 32'(d0_gen_env_addr), 32'h001);
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t5_ab_valid", 32'(d0_gen_valid), 32'd0);
    chk("t5_ab_busy", 32'(d0_busy), 32'd0);
    chk("t5_ab_done", 32'(d0_pulses_done), 32'd5);
    abort = 1'b1; in_valid = 1'b1; setp(32'd320, 16'd3, 10'h000);
    #1;
    chk("t5_idle_ab_ready", 32'(d0_in_ready), 32'd0);
    tick(); abort = 1'b0; in_valid = 1'b0;
    chk("t5_idle_ab_busy", 32'(d0_busy), 32'd0);
    setp(counter + 32'd5, 16'd0, 10'h000); in_valid = 1'b1;
    #1;
    chk("t5_z_ready", 32'(d0_in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    chk("t5_z_busy", 32'(d0_busy), 32'd0);
    repeat (8) tick();
    chk("t5_z_valid", 32'(d0_gen_valid), 32'd0);
    chk("t5_z_done", 32'(d0_pulses_done), 32'd5);

    // 6: asynchronous reset mid-play, then enable low blocks accepts
    counter = 32'd400; setp(32'd402, 16'd5, 10'h077); in_valid = 1'b1;
    #1;
    tick(); in_valid = 1'b0;
    repeat (3) tick();
    chk("t6_play_valid", 32'(d0_gen_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(d0_gen_valid), 32'd0);
    chk("t6_rst_busy", 32'(d0_busy), 32'd0);
    chk("t6_rst_done", 32'(d0_pulses_done), 32'd0);
    chk("t6_rst_lcnt", 32'(d0_late_count), 32'd0);
    chk("t6_rst_env", 32'(d0_gen_env_addr), 32'd0);
    chk("t6_rst_freq", d0_gen_freq, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b0; in_valid = 1'b1; setp(counter + 32'd3, 16'd2, 10'h000);
    #1;
    chk("t6_en_ready", 32'(d0_in_ready), 32'd0);
    tick();
    chk("t6_en_busy", 32'(d0_busy), 32'd0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
